sar_logic_10bit: RTL and testbench

SAR_LOGIC_10BIT -- requirements
Module: sar_logic_10bit

---
 rtl/sar_pkg.sv | 14 +
 rtl/sar_logic_10bit.sv | 82 ++++++++
 tb/tb_sar_logic_10bit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/sar_pkg.sv
// Shared types and defaults for the SAR conversion controller.
// Holds the controller state encoding and the default resolution.
package sar_pkg;

    localparam int SAR_N_BITS = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } sar_state_t;

endpackage

// File: rtl/sar_logic_10bit.sv
// Free-running successive-approximation controller.
// Fixed-length sample/convert/done cycle with all outputs registered.
module sar_logic_10bit
    import sar_pkg::*;
#(
    parameter int N_BITS        = SAR_N_BITS,
    parameter int SAMPLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              comparator_out,
    output logic [N_BITS-1:0] D,
    output logic              sample_clk,
    output logic              reg_clk,
    output logic              EOC
);

    localparam int IW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(N_BITS - 1);
    localparam logic [3:0] SC_LAST = 4'(SAMPLE_CYCLES - 1);
    localparam logic [N_BITS-1:0] MSB_TRIAL = {1'b1, {(N_BITS-1){1'b0}}};

    sar_state_t    state;
    logic [IW-1:0] idx;
    logic [3:0]    samp_cnt;

    // Sequencer and trial register; comparator used only while converting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            D          <= '0;
            sample_clk <= 1'b0;
            reg_clk    <= 1'b0;
            EOC        <= 1'b0;
            idx        <= IDX_TOP;
            samp_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state      <= SAMPLE;
                    sample_clk <= 1'b1;
                    D          <= '0;
                    samp_cnt   <= '0;
                end
                SAMPLE: begin
                    if (samp_cnt == SC_LAST) begin
                        state      <= CONVERT;
                        sample_clk <= 1'b0;
                        reg_clk    <= 1'b1;
                        D          <= MSB_TRIAL;
                        idx        <= IDX_TOP;
                    end else begin
                        samp_cnt <= samp_cnt + 4'd1;
                    end
                end
                CONVERT: begin
                    D[idx] <= comparator_out;
                    if (idx != '0) begin
                        D[idx - 1'b1] <= 1'b1;
                        idx           <= idx - 1'b1;
                    end else begin
                        state   <= DONE;
                        reg_clk <= 1'b0;
                        EOC     <= 1'b1;
                    end
                end
                DONE: begin
                    state      <= SAMPLE;
                    EOC        <= 1'b0;
                    sample_clk <= 1'b1;
                    D          <= '0;
                    samp_cnt   <= '0;
                    idx        <= IDX_TOP;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_logic_10bit.sv
// Directed bench for the SAR controller.
// Walks conversions edge by edge against a bench-side trial model.
module tb_sar_logic_10bit;

    logic       clk;
    logic       rst_n;
    logic       comparator_out;
    logic [9:0] D;
    logic       sample_clk;
    logic       reg_clk;
    logic       EOC;

    int n_cmp = 0;
    int n_err = 0;

    sar_logic_10bit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .comparator_out (comparator_out),
        .D              (D),
        .sample_clk     (sample_clk),
        .reg_clk        (reg_clk),
        .EOC            (EOC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [9:0] obs,
                         input logic [9:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expects to be called one cycle into SAMPLE; leaves DUT one cycle into
    // the next SAMPLE. pat is the comparator decision per bit, MSB first.
    task automatic do_conv(input string tag, input logic [9:0] pat,
                           input logic [9:0] fin);
        logic [9:0] code;
        logic [9:0] trial;
        code = '0;
        check({tag, " sample flags"}, {7'd0, sample_clk, reg_clk, EOC},
              10'b100);
        check({tag, " sample D"}, D, 10'h000);
        comparator_out = ~pat[9];
        step();
        for (int i = 9; i >= 0; i--) begin
            trial = code;
            trial[i] = 1'b1;
            check($sformatf("%s conv%0d flags", tag, 9 - i),
                  {7'd0, sample_clk, reg_clk, EOC}, 10'b010);
            check($sformatf("%s conv%0d D", tag, 9 - i), D, trial);
            comparator_out = pat[i];
            code = trial;
            code[i] = pat[i];
            step();
        end
        check({tag, " done flags"}, {7'd0, sample_clk, reg_clk, EOC},
              10'b001);
        check({tag, " done D"}, D, fin);
        check({tag, " done model"}, D, code);
        comparator_out = ~comparator_out;
        step();
    endtask

    initial begin
        logic [9:0] r;
        rst_n = 1'b0;
        comparator_out = 1'b1;
        #2;
        check("rst flags", {7'd0, sample_clk, reg_clk, EOC}, 10'b000);
        check("rst D", D, 10'h000);
        step();
        step();
        check("rst held flags", {7'd0, sample_clk, reg_clk, EOC}, 10'b000);
        rst_n = 1'b1;
        check("idle D", D, 10'h000);
        step();

        do_conv("ones", 10'h3FF, 10'h3FF);
        do_conv("zeros", 10'h000, 10'h000);
        do_conv("alt10", 10'h2AA, 10'h2AA);
        do_conv("alt01", 10'h155, 10'h155);
        for (int k = 0; k < 16; k++) begin
            r = 10'($urandom);
            do_conv($sformatf("rand%0d", k), r, r);
        end

        // abort mid-conversion: into SAMPLE already, go 5 CONVERT cycles
        comparator_out = 1'b1;
        step();
        for (int i = 0; i < 4; i++) step();
        check("pre-abort reg_clk", {9'd0, reg_clk}, 10'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort flags", {7'd0, sample_clk, reg_clk, EOC}, 10'b000);
        check("abort D", D, 10'h000);
        step();
        step();
        check("abort held EOC", {9'd0, EOC}, 10'd0);
        rst_n = 1'b1;
        check("abort idle D", D, 10'h000);
        step();
        do_conv("after abort", 10'h2C5, 10'h2C5);
        do_conv("b2b", 10'h0F0, 10'h0F0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
